// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, ALU codes, immediate formats and decode
// helpers shared by the decode/issue stage.
package decode_pkg;

    localparam int RW = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

    typedef enum logic {
        EMPTY,
        HELD
    } stage_state_t;

    localparam int CTRL_JUMP   = 0;
    localparam int CTRL_BRANCH = 1;
    localparam int CTRL_STORE  = 2;
    localparam int CTRL_LOAD   = 3;

    // alt selects SUB/SRA; callers mask it for OP_IMM
    function automatic alu_op_t alu_from_f3(
        input logic [2:0] f3,
        input logic       alt
    );
        alu_op_t op;
        unique case (f3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] gen_imm(
        input logic [31:0] i,
        input imm_fmt_t    f
    );
        logic [31:0] v;
        unique case (f)
            IMM_I:   v = {{20{i[31]}}, i[31:20]};
            IMM_S:   v = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   v = {{19{i[31]}}, i[31], i[7],
                          i[30:25], i[11:8], 1'b0};
            IMM_U:   v = {i[31:12], 12'b0};
            IMM_J:   v = {{11{i[31]}}, i[31], i[19:12],
                          i[20], i[30:21], 1'b0};
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/decode_issue_scoreboard.sv
// decode_issue_scoreboard: one busy bit per register, x0 never busy.
// Set at issue, cleared at writeback; set wins on a collision.
module decode_issue_scoreboard
    import decode_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_en,
    input  logic [RW-1:0] set_idx,
    input  logic          clr_en,
    input  logic [RW-1:0] clr_idx,
    input  logic [RW-1:0] rd_a,
    input  logic [RW-1:0] rd_b,
    input  logic [RW-1:0] rd_c,
    output logic          busy_a,
    output logic          busy_b,
    output logic          busy_c
);

    logic [NREGS-1:1] busy;
    logic [NREGS-1:0] busy_full;

    assign busy_full = {busy, 1'b0};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (set_en && int'(set_idx) == i)
                    busy[i] <= 1'b1;
                else if (clr_en && int'(clr_idx) == i)
                    busy[i] <= 1'b0;
            end
        end
    end

    assign busy_a = busy_full[rd_a];
    assign busy_b = busy_full[rd_b];
    assign busy_c = busy_full[rd_c];

endmodule

// File: rtl/decode_issue.sv
// decode_issue: holds one fetched instruction, decodes it and issues
// operands to execute once the scoreboard shows no RAW/WAW hazard.
module decode_issue
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [RW-1:0]   rs1,
    output logic [RW-1:0]   rs2,
    input  logic [XLEN-1:0] rs1_out,
    input  logic [XLEN-1:0] rs2_out,
    input  logic            wb_valid,
    input  logic [RW-1:0]   wb_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [XLEN-1:0] out_imm,
    output logic [RW-1:0]   out_rd,
    output logic            out_wen,
    output logic [3:0]      out_alu_op,
    output logic [3:0]      out_ctrl,
    output logic            out_illegal
);

    stage_state_t    state;
    logic [31:0]     held_instr;
    logic [XLEN-1:0] held_pc;

    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [RW-1:0] rd;

    assign opcode = held_instr[6:0];
    assign funct3 = held_instr[14:12];
    assign rd     = held_instr[11:7];
    assign rs1    = held_instr[19:15];
    assign rs2    = held_instr[24:20];

    logic     uses_rs1;
    logic     uses_rs2;
    logic     writes_rd;
    logic     illegal;
    imm_fmt_t imm_fmt;
    alu_op_t  alu_op;
    logic [3:0] ctrl;

    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        illegal   = 1'b0;
        imm_fmt   = IMM_NONE;
        alu_op    = ALU_ADD;
        ctrl      = '0;
        unique case (1'b1)
            (opcode == OPC_LUI): begin
                writes_rd = 1'b1;
                imm_fmt   = IMM_U;
                alu_op    = ALU_PASS;
            end
            (opcode == OPC_AUIPC): begin
                writes_rd = 1'b1;
                imm_fmt   = IMM_U;
            end
            (opcode == OPC_JAL): begin
                writes_rd       = 1'b1;
                imm_fmt         = IMM_J;
                ctrl[CTRL_JUMP] = 1'b1;
            end
            (opcode == OPC_JALR): begin
                uses_rs1        = 1'b1;
                writes_rd       = 1'b1;
                imm_fmt         = IMM_I;
                ctrl[CTRL_JUMP] = 1'b1;
            end
            (opcode == OPC_BRANCH): begin
                uses_rs1          = 1'b1;
                uses_rs2          = 1'b1;
                imm_fmt           = IMM_B;
                ctrl[CTRL_BRANCH] = 1'b1;
                unique case (funct3[2:1])
                    2'b10:   alu_op = ALU_SLT;
                    2'b11:   alu_op = ALU_SLTU;
                    default: alu_op = ALU_SUB;
                endcase
            end
            (opcode == OPC_LOAD): begin
                uses_rs1        = 1'b1;
                writes_rd       = 1'b1;
                imm_fmt         = IMM_I;
                ctrl[CTRL_LOAD] = 1'b1;
            end
            (opcode == OPC_STORE): begin
                uses_rs1         = 1'b1;
                uses_rs2         = 1'b1;
                imm_fmt          = IMM_S;
                ctrl[CTRL_STORE] = 1'b1;
            end
            (opcode == OPC_OP_IMM): begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                imm_fmt   = IMM_I;
                alu_op    = alu_from_f3(funct3,
                    held_instr[30] & (funct3 == 3'd5));
            end
            (opcode == OPC_OP): begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
                alu_op    = alu_from_f3(funct3, held_instr[30]);
            end
            default: illegal = 1'b1;
        endcase
    end

    logic            wen;
    logic [XLEN-1:0] imm;

    assign wen = writes_rd & (rd != '0);
    assign imm = XLEN'($signed(gen_imm(held_instr, imm_fmt)));

    logic busy_a;
    logic busy_b;
    logic busy_c;
    logic hazard;
    logic issue;
    logic accept;

    decode_issue_scoreboard #(
        .NREGS(NREGS)
    ) u_sb (
        .clk    (clk),
        .rst_n  (rst_n),
        .set_en (issue & wen),
        .set_idx(rd),
        .clr_en (wb_valid),
        .clr_idx(wb_rd),
        .rd_a   (rs1),
        .rd_b   (rs2),
        .rd_c   (rd),
        .busy_a (busy_a),
        .busy_b (busy_b),
        .busy_c (busy_c)
    );

    assign hazard = (busy_a & uses_rs1)
                  | (busy_b & uses_rs2)
                  | (busy_c & wen);
    assign issue  = (state == HELD) & ~hazard
                  & (~out_valid | out_ready);
    assign in_ready = (state == EMPTY) | issue;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= EMPTY;
            held_instr  <= '0;
            held_pc     <= '0;
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_op1     <= '0;
            out_op2     <= '0;
            out_imm     <= '0;
            out_rd      <= '0;
            out_wen     <= 1'b0;
            out_alu_op  <= '0;
            out_ctrl    <= '0;
            out_illegal <= 1'b0;
        end else begin
            unique case (state)
                EMPTY: if (accept) state <= HELD;
                HELD:  if (issue && !accept) state <= EMPTY;
            endcase
            if (accept) begin
                held_instr <= in_instr;
                held_pc    <= in_pc;
            end
            if (issue) begin
                out_valid   <= 1'b1;
                out_pc      <= held_pc;
                out_op1     <= uses_rs1 ? rs1_out : '0;
                out_op2     <= uses_rs2 ? rs2_out : '0;
                out_imm     <= imm;
                out_rd      <= writes_rd ? rd : '0;
                out_wen     <= wen;
                out_alu_op  <= alu_op;
                out_ctrl    <= ctrl;
                out_illegal <= illegal;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed scenarios plus a randomized stream
// checked against a transaction-level model of decode and issue.
module tb_decode_issue;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_out;
    logic [31:0] rs2_out;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [31:0] out_imm;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic [3:0]  out_alu_op;
    logic [3:0]  out_ctrl;
    logic        out_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rf [32];

    always #5 clk = ~clk;

    assign rs1_out = rf[rs1];
    assign rs2_out = rf[rs2];

    decode_issue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .rs1        (rs1),
        .rs2        (rs2),
        .rs1_out    (rs1_out),
        .rs2_out    (rs2_out),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_op1    (out_op1),
        .out_op2    (out_op2),
        .out_imm    (out_imm),
        .out_rd     (out_rd),
        .out_wen    (out_wen),
        .out_alu_op (out_alu_op),
        .out_ctrl   (out_ctrl),
        .out_illegal(out_illegal)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        wen;
        logic [3:0]  alu;
        logic [3:0]  ctrl;
        logic        ill;
    } exp_t;

    function automatic logic [31:0] enc_i(input logic [6:0] opc,
        input logic [4:0] rd, input logic [2:0] f3,
        input logic [4:0] r1, input int imm);
        logic [31:0] v = 32'(imm);
        return {v[11:0], r1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rd,
        input logic [4:0] r1, input logic [4:0] r2,
        input logic [6:0] f7);
        return {f7, r2, r1, 3'd0, rd, OPC_OP};
    endfunction

    function automatic logic [31:0] enc_s(input logic [4:0] r1,
        input logic [4:0] r2, input int imm);
        logic [31:0] v = 32'(imm);
        return {v[11:5], r2, r1, 3'd2, v[4:0], OPC_STORE};
    endfunction

    function automatic logic [31:0] enc_b(input logic [4:0] r1,
        input logic [4:0] r2, input int imm);
        logic [31:0] v = 32'(imm);
        return {v[12], v[10:5], r2, r1, 3'd0, v[4:1], v[11],
                OPC_BRANCH};
    endfunction

    function automatic logic [31:0] enc_u(input logic [4:0] rd,
        input logic [31:0] v);
        return {v[31:12], rd, OPC_LUI};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] rd,
        input int imm);
        logic [31:0] v = 32'(imm);
        return {v[20], v[10:1], v[11], v[19:12], rd, OPC_JAL};
    endfunction

    // Expected bundle built from what the generator chose, not
    // from decoding the instruction bits.
    function automatic exp_t gen(input logic [31:0] pc);
        exp_t e;
        int kind;
        int imm;
        logic writes;
        logic [4:0] rd;
        logic [4:0] r1;
        logic [4:0] r2;
        logic [31:0] r;
        kind = $urandom_range(0, 8);
        rd = 5'($urandom_range(0, 7));
        r1 = 5'($urandom_range(0, 7));
        r2 = 5'($urandom_range(0, 7));
        imm = int'($urandom_range(0, 4095)) - 2048;
        e.pc = pc;
        e.op1 = '0;
        e.op2 = '0;
        e.imm = '0;
        e.alu = ALU_ADD;
        e.ctrl = '0;
        e.ill = 1'b0;
        writes = 1'b1;
        case (kind)
            0: begin
                e.instr = enc_i(OPC_OP_IMM, rd, 3'd0, r1, imm);
                e.op1 = rf[r1];
                e.imm = 32'(imm);
            end
            1: begin
                e.instr = enc_r(rd, r1, r2, 7'h00);
                e.op1 = rf[r1];
                e.op2 = rf[r2];
            end
            2: begin
                e.instr = enc_r(rd, r1, r2, 7'h20);
                e.op1 = rf[r1];
                e.op2 = rf[r2];
                e.alu = ALU_SUB;
            end
            3: begin
                e.instr = enc_i(OPC_LOAD, rd, 3'd2, r1, imm);
                e.op1 = rf[r1];
                e.imm = 32'(imm);
                e.ctrl = 4'b1000;
            end
            4: begin
                e.instr = enc_s(r1, r2, imm);
                e.op1 = rf[r1];
                e.op2 = rf[r2];
                e.imm = 32'(imm);
                e.ctrl = 4'b0100;
                writes = 1'b0;
            end
            5: begin
                e.instr = enc_b(r1, r2, imm * 2);
                e.op1 = rf[r1];
                e.op2 = rf[r2];
                e.imm = 32'(imm * 2);
                e.alu = ALU_SUB;
                e.ctrl = 4'b0010;
                writes = 1'b0;
            end
            6: begin
                r = $urandom();
                e.imm = {r[31:12], 12'h000};
                e.instr = enc_u(rd, e.imm);
                e.alu = ALU_PASS;
            end
            7: begin
                imm = int'($urandom_range(0, 1048575)) - 524288;
                e.instr = enc_j(rd, imm * 2);
                e.imm = 32'(imm * 2);
                e.ctrl = 4'b0001;
            end
            default: begin
                r = $urandom();
                e.instr = {r[31:7], 7'h7F};
                e.ill = 1'b1;
                writes = 1'b0;
            end
        endcase
        e.rd  = writes ? rd : 5'd0;
        e.wen = writes && rd != 5'd0;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        wb_valid = 1'b0;
        wb_rd = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] a5;
        logic [31:0] a6;
        a5 = enc_i(OPC_OP_IMM, 5'd5, 3'd0, 5'd0, 7);
        a6 = enc_r(5'd6, 5'd5, 5'd5, 7'h00);
        rst_n = 1'b0;
        wb_valid = 1'b0;
        wb_rd = '0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_pc = 32'h100;
        in_instr = enc_i(OPC_OP_IMM, 5'd1, 3'd0, 5'd0, 5);
        repeat (3) tick();
        rst_n = 1'b1;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_hs got v/r=%b want 01",
                     {out_valid, in_ready});
        end
        n_checks++;
        if ({out_pc, out_op1, out_op2, out_imm, out_rd, out_wen,
             out_alu_op, out_ctrl, out_illegal} !== '0) begin
            n_fail++;
            $display("FAIL reset_out got pc=%h rd=%h want 0",
                     out_pc, out_rd);
        end
        // stall on x5, then reset while the dependent is held
        in_valid = 1'b1;
        in_instr = a5;
        tick();
        in_instr = a6;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_discard got v/r=%b want 01",
                     {out_valid, in_ready});
        end
        in_valid = 1'b1;
        in_pc = 32'h104;
        tick();
        in_valid = 1'b0;
        tick();
        n_checks++;
        if ({out_valid, out_rd, out_op1} !== {1'b1, 5'd6, rf[5]})
        begin
            n_fail++;
            $display("FAIL reset_busy got v=%b rd=%0d op1=%h want 1 6 %h",
                     out_valid, out_rd, out_op1, rf[5]);
        end
    endtask

    task automatic test_raw();
        do_reset();
        in_valid = 1'b1;
        in_pc = 32'h10;
        in_instr = enc_i(OPC_OP_IMM, 5'd1, 3'd0, 5'd0, 5);
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL raw_b2b got in_ready=%b want 1", in_ready);
        end
        in_pc = 32'h14;
        in_instr = enc_r(5'd2, 5'd1, 5'd1, 7'h00);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_rd, out_wen, out_imm, out_op1, out_pc}
            !== {1'b1, 5'd1, 1'b1, 32'd5, 32'd0, 32'h10}) begin
            n_fail++;
            $display("FAIL raw_first got v=%b rd=%0d imm=%h op1=%h",
                     out_valid, out_rd, out_imm, out_op1);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if ({out_valid, in_ready} !== 2'b00) begin
                n_fail++;
                $display("FAIL raw_stall got v/r=%b want 00",
                         {out_valid, in_ready});
            end
        end
        wb_valid = 1'b1;
        wb_rd = 5'd1;
        tick();
        wb_valid = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL raw_wb got v/r=%b want 01",
                     {out_valid, in_ready});
        end
        tick();
        n_checks++;
        if ({out_valid, out_rd, out_op1, out_op2, out_alu_op}
            !== {1'b1, 5'd2, rf[1], rf[1], 4'(ALU_ADD)}) begin
            n_fail++;
            $display("FAIL raw_issue got v=%b rd=%0d op=%h/%h want %h",
                     out_valid, out_rd, out_op1, out_op2, rf[1]);
        end
    endtask

    task automatic test_stream();
        int imms [8];
        do_reset();
        for (int k = 0; k < 8; k++)
            imms[k] = int'($urandom_range(0, 4095)) - 2048;
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) begin
                in_valid = 1'b1;
                in_pc = 32'h200 + 32'(4 * k);
                in_instr = enc_i(OPC_OP_IMM, 5'(8 + k), 3'd0,
                                 5'(20 + k), imms[k]);
                #1;
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_ready k=%0d got %b want 1",
                             k, in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (k > 0) begin
                n_checks++;
                if ({out_valid, out_rd, out_pc, out_op1, out_imm} !==
                    {1'b1, 5'(7 + k), 32'h200 + 32'(4 * (k - 1)),
                     rf[19 + k], 32'(imms[k - 1])}) begin
                    n_fail++;
                    $display("FAIL stream_bundle k=%0d got v=%b rd=%0d imm=%h",
                             k - 1, out_valid, out_rd, out_imm);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ia;
        do_reset();
        ia = 32'(int'($urandom_range(0, 4095)) - 2048);
        ia = {{20{ia[11]}}, ia[11:0]};
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_pc = 32'h300;
        in_instr = enc_i(OPC_OP_IMM, 5'd4, 3'd0, 5'd0, int'(ia));
        tick();
        in_pc = 32'h304;
        in_instr = enc_i(OPC_OP_IMM, 5'd5, 3'd0, 5'd9, 100);
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if ({out_valid, in_ready, out_pc, out_rd, out_imm} !==
                {2'b10, 32'h300, 5'd4, ia}) begin
                n_fail++;
                $display("FAIL bp_hold c=%0d got v/r=%b pc=%h imm=%h",
                         c, {out_valid, in_ready}, out_pc, out_imm);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        tick();
        n_checks++;
        if ({out_valid, out_pc, out_rd, out_op1, out_imm} !==
            {1'b1, 32'h304, 5'd5, rf[9], 32'd100}) begin
            n_fail++;
            $display("FAIL bp_release got v=%b pc=%h rd=%0d",
                     out_valid, out_pc, out_rd);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_set_wins();
        do_reset();
        in_valid = 1'b1;
        in_pc = 32'h400;
        in_instr = enc_i(OPC_OP_IMM, 5'd3, 3'd0, 5'd0, 1);
        tick();
        wb_valid = 1'b1;
        wb_rd = 5'd3;
        in_pc = 32'h404;
        in_instr = enc_r(5'd7, 5'd3, 5'd0, 7'h00);
        tick();
        wb_valid = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL setwins_stall c=%0d got v=%b want 0",
                         c, out_valid);
            end
        end
        wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        tick();
        n_checks++;
        if ({out_valid, out_rd, out_op1} !== {1'b1, 5'd7, rf[3]})
        begin
            n_fail++;
            $display("FAIL setwins_issue got v=%b rd=%0d op1=%h",
                     out_valid, out_rd, out_op1);
        end
        in_valid = 1'b1;
        in_instr = enc_i(OPC_OP_IMM, 5'd0, 3'd0, 5'd0, 1);
        tick();
        in_valid = 1'b0;
        tick();
        n_checks++;
        if ({out_valid, out_wen, out_rd} !== {1'b1, 1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL x0_wen got v=%b wen=%b rd=%0d want 1 0 0",
                     out_valid, out_wen, out_rd);
        end
    endtask

    task automatic test_imm();
        logic [31:0] ins [5];
        logic [31:0] eimm [5];
        logic [3:0]  ectl [5];
        logic [1:0]  efl [5];
        ins[0] = enc_s(5'd1, 5'd2, -4);
        ins[1] = enc_b(5'd1, 5'd2, -8);
        ins[2] = enc_j(5'd0, 2048);
        ins[3] = enc_u(5'd9, 32'h12345000);
        ins[4] = 32'h1234_5FFF;
        eimm = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000800,
                 32'h12345000, 32'h0};
        ectl = '{4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b0000};
        efl  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_pc = 32'h500 + 32'(4 * k);
            in_instr = ins[k];
            tick();
            in_valid = 1'b0;
            tick();
            n_checks++;
            if ({out_valid, out_imm, out_ctrl, out_illegal, out_wen}
                !== {1'b1, eimm[k], ectl[k], efl[k]}) begin
                n_fail++;
                $display("FAIL imm k=%0d got v=%b imm=%h ctl=%b il/w=%b want %h %b %b",
                         k, out_valid, out_imm, out_ctrl,
                         {out_illegal, out_wen}, eimm[k], ectl[k],
                         efl[k]);
            end
        end
    endtask

    task automatic test_random();
        localparam int N = 60;
        localparam int BUDGET = 3000;
        exp_t q[$];
        logic [4:0] wbq[$];
        int got;
        int cyc;
        bit stop;
        got = 0;
        cyc = 0;
        stop = 1'b0;
        do_reset();
        fork
            begin
                for (int k = 0; k < N && !stop; k++) begin
                    exp_t e;
                    bit acc;
                    e = gen(32'h1000 + 32'(4 * k));
                    q.push_back(e);
                    in_valid = 1'b1;
                    in_instr = e.instr;
                    in_pc = e.pc;
                    acc = 1'b0;
                    while (!acc && !stop) begin
                        @(negedge clk);
                        acc = in_ready;
                        tick();
                    end
                end
                in_valid = 1'b0;
            end
            begin
                while (!stop) begin
                    tick();
                    cyc++;
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (wbq.size() > 0) begin
                        wb_valid = 1'b1;
                        wb_rd = wbq.pop_front();
                    end else begin
                        wb_valid = 1'b0;
                    end
                    if (got == N || cyc > BUDGET) stop = 1'b1;
                end
            end
            begin
                while (!stop) begin
                    @(negedge clk);
                    if (out_valid && out_ready && q.size() > 0) begin
                        exp_t e;
                        e = q.pop_front();
                        n_checks++;
                        if ({out_pc, out_op1, out_op2, out_imm} !==
                            {e.pc, e.op1, e.op2, e.imm}) begin
                            n_fail++;
                            $display("FAIL rand_data pc=%h got %h %h %h want %h %h %h",
                                     e.pc, out_op1, out_op2, out_imm,
                                     e.op1, e.op2, e.imm);
                        end
                        n_checks++;
                        if ({out_rd, out_wen, out_alu_op, out_ctrl,
                             out_illegal} !== {e.rd, e.wen, e.alu,
                             e.ctrl, e.ill}) begin
                            n_fail++;
                            $display("FAIL rand_ctrl pc=%h got rd=%0d w=%b a=%h c=%b i=%b",
                                     e.pc, out_rd, out_wen, out_alu_op,
                                     out_ctrl, out_illegal);
                        end
                        if (e.wen) wbq.push_back(e.rd);
                        got++;
                    end
                end
            end
        join
        wb_valid = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (got != N) begin
            n_fail++;
            $display("FAIL rand_count got %0d bundles want %0d", got, N);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom();
        rf[0] = '0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        in_pc = '0;
        wb_valid = 1'b0;
        wb_rd = '0;
        out_ready = 1'b1;
        test_reset();
        test_raw();
        test_stream();
        test_backpressure();
        test_set_wins();
        test_imm();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
